// File: rtl/pb_pulse_bank.sv
// pb_pulse_bank
//   Multi-channel push-button conditioner. Every channel is independent and
//   has its own 2-flop synchroniser, stable-count debouncer, one-cycle press
//   and release strobes, and a long-press auto-repeat FSM (IDLE/HOLD/REPEAT).
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   rst_n          asynchronous active-low reset, clears all state
//   pb_in[N]       raw, asynchronous, bouncing button levels (1 = pressed)
//   repeat_en[N]   per-channel auto-repeat enable, synchronous to clk
//   pb_level[N]    debounced button level
//   press_pulse[N] one-cycle strobe, one clock after pb_level rises
//   release_pulse[N] one-cycle strobe, one clock after pb_level falls
//   repeat_pulse[N]  one-cycle auto-repeat strobe while the button is held
//   held[N]        1 while the channel is in REPEAT (lags the state by a cycle)
module pb_pulse_bank #(
    parameter int N             = 4,
    parameter int DEB_CYCLES    = 16,
    parameter int HOLD_CYCLES   = 100,
    parameter int REPEAT_CYCLES = 20,
    parameter int CNT_W         = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] pb_in,
    input  logic [N-1:0] repeat_en,
    output logic [N-1:0] pb_level,
    output logic [N-1:0] press_pulse,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] repeat_pulse,
    output logic [N-1:0] held
);

    // Terminal counts: each counter runs 0 .. X-1, so the compare is against X-1.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic             sync_q1;
        logic             sync_q2;
        logic [CNT_W-1:0] deb_cnt;
        logic             level_q;
        logic             level_d;
        logic             press_q;
        logic             release_q;
        logic             repeat_q;
        logic             held_q;
        logic [1:0]       state;
        logic [CNT_W-1:0] rcnt;
        logic             rise;
        logic             fall;

        // Edge detect on the debounced level; the strobes register these.
        assign rise = level_q & ~level_d;
        assign fall = ~level_q & level_d;

        // Synchroniser and debouncer. pb_level only toggles after the
        // synchronised input has disagreed with it for DEB_CYCLES edges.
        // NOTE: every flop here, counters included, is cleared by rst_n so a
        // press still present at reset release is seen as a fresh press.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q1 <= 1'b0;
                sync_q2 <= 1'b0;
                deb_cnt <= '0;
                level_q <= 1'b0;
                level_d <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments so every flop samples the
                // pre-edge value of its source, giving a true 2-stage chain.
                sync_q1 <= pb_in[i];
                sync_q2 <= sync_q1;
                level_d <= level_q;
                if (sync_q2 == level_q) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == DEB_LAST) begin
                    level_q <= ~level_q;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end
        end

        // Registered press/release strobes; rise and fall are exclusive.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= rise;
                release_q <= fall;
            end
        end

        // Auto-repeat FSM. A release always wins over a coincident repeat
        // boundary, and HOLD parks at its terminal count while repeat_en is
        // low so that raising it fires a repeat on the very next edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= ST_IDLE;
                rcnt     <= '0;
                repeat_q <= 1'b0;
                held_q   <= 1'b0;
            end else begin
                repeat_q <= 1'b0;
                held_q   <= (state == ST_REPEAT);
                if (fall) begin
                    state <= ST_IDLE;
                    rcnt  <= '0;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (rise) begin
                                state <= ST_HOLD;
                                rcnt  <= '0;
                            end
                        end
                        ST_HOLD: begin
                            if (rcnt == HOLD_LAST) begin
                                if (repeat_en[i]) begin
                                    repeat_q <= 1'b1;
                                    rcnt     <= '0;
                                    state    <= ST_REPEAT;
                                end
                            end else begin
                                rcnt <= rcnt + 1'b1;
                            end
                        end
                        ST_REPEAT: begin
                            if (!repeat_en[i]) begin
                                state <= ST_HOLD;
                                rcnt  <= HOLD_LAST;
                            end else if (rcnt == REP_LAST) begin
                                repeat_q <= 1'b1;
                                rcnt     <= '0;
                            end else begin
                                rcnt <= rcnt + 1'b1;
                            end
                        end
                        default: begin
                            state <= ST_IDLE;
                            rcnt  <= '0;
                        end
                    endcase
                end
            end
        end

        assign pb_level[i]      = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign repeat_pulse[i]  = repeat_q;
        assign held[i]          = held_q;
    end

endmodule

// File: tb/tb_pb_pulse_bank.sv
// Self-checking bench for pb_pulse_bank with N=2, DEB_CYCLES=4,
// HOLD_CYCLES=10, REPEAT_CYCLES=3. Inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_pb_pulse_bank;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] pb_in;
    logic [N-1:0] repeat_en;
    logic [N-1:0] pb_level;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] repeat_pulse;
    logic [N-1:0] held;

    pb_pulse_bank #(
        .N            (2),
        .DEB_CYCLES   (4),
        .HOLD_CYCLES  (10),
        .REPEAT_CYCLES(3),
        .CNT_W        (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pb_in        (pb_in),
        .repeat_en    (repeat_en),
        .pb_level     (pb_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] pb;
        logic [1:0] ren;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        logic [1:0] rpt;
        logic [1:0] hld;
    } vec_t;

    vec_t vecs[24];

    int total = 0;
    int bad   = 0;
    int n;
    int m;
    int press_cnt0, press_cnt1, rel_cnt0, rel_cnt1;
    logic ch1_any;
    logic lvl_moved;
    logic [1:0] e_lvl, e_prs, e_rel, e_rpt, e_hld;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, 32'({pb_level, press_pulse, release_pulse, repeat_pulse, held}), 32'd0);
    endtask

    task automatic clear_counts();
        press_cnt0 = 0; press_cnt1 = 0; rel_cnt0 = 0; rel_cnt1 = 0;
        ch1_any    = 1'b0;
    endtask

    // One clock: advance past the edge, then tally strobes seen this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        press_cnt0 += int'(press_pulse[0]);
        press_cnt1 += int'(press_pulse[1]);
        rel_cnt0   += int'(release_pulse[0]);
        rel_cnt1   += int'(release_pulse[1]);
        ch1_any    |= pb_level[1] | press_pulse[1] | release_pulse[1] | repeat_pulse[1] | held[1];
    endtask

    task automatic go_quiet(input string name);
        pb_in     = 2'b00;
        repeat_en = 2'b00;
        for (int k = 0; k < 15; k++) tick();
        check(name, 32'({pb_level, held}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset with buttons already pressed ----------------
        rst_n     = 1'b0;
        pb_in     = 2'b11;
        repeat_en = 2'b00;
        clear_counts();
        #3;
        check_zero("rst_initial");
        for (int k = 0; k < 5; k++) begin
            tick();
            check_zero($sformatf("rst_hold%0d", k));
        end
        #2;
        rst_n = 1'b1;
        clear_counts();
        n = 0;
        while (pb_level != 2'b11 && n < 20) begin
            tick();
            n++;
        end
        check_range("rst_level_edges", n, 6, 7);
        tick();
        check("rst_press_next", 32'(press_pulse), 32'(2'b11));
        for (int k = 0; k < 10; k++) tick();
        check("rst_press_count", 32'({press_cnt1[7:0], press_cnt0[7:0]}), 32'h0101);
        check("rst_no_release", 32'({rel_cnt1[7:0], rel_cnt0[7:0]}), 32'h0000);
        go_quiet("rst_quiet");

        // ---------------- table: clean press, glitch, release ---------------
        // ch0 rises at row 0 -> level at row 5, press at row 6;
        // ch1 3-cycle glitch at rows 8..10 -> nothing;
        // ch0 falls at row 16 -> level 0 at row 21, release at row 22.
        for (int r = 0; r < 24; r++) begin
            vecs[r].pb  = (r < 16) ? 2'b01 : 2'b00;
            if (r >= 8 && r <= 10) vecs[r].pb = 2'b11;
            vecs[r].ren = 2'b00;
            vecs[r].lvl = (r >= 5 && r <= 20) ? 2'b01 : 2'b00;
            vecs[r].prs = (r == 6)  ? 2'b01 : 2'b00;
            vecs[r].rel = (r == 22) ? 2'b01 : 2'b00;
            vecs[r].rpt = 2'b00;
            vecs[r].hld = 2'b00;
        end
        for (int r = 0; r < 24; r++) begin
            pb_in     = vecs[r].pb;
            repeat_en = vecs[r].ren;
            tick();
            check($sformatf("vec%0d", r),
                  32'({pb_level, press_pulse, release_pulse, repeat_pulse, held}),
                  32'({vecs[r].lvl, vecs[r].prs, vecs[r].rel, vecs[r].rpt, vecs[r].hld}));
        end
        go_quiet("tbl_quiet");

        // ---------------- bounce on ch0 ----------------
        clear_counts();
        lvl_moved = 1'b0;
        for (int k = 0; k < 20; k++) begin
            pb_in[0] = ((k / 2) % 2 == 0);
            tick();
            lvl_moved |= pb_level[0];
        end
        check("bnc_no_level", 32'(lvl_moved), 32'd0);
        pb_in[0] = 1'b1;
        n = 0;
        while (!pb_level[0] && n < 20) begin
            tick();
            n++;
        end
        check_range("bnc_level_edges", n, 6, 7);
        for (int k = 0; k < 10; k++) tick();
        check("bnc_press_count", 32'(press_cnt0), 32'd1);
        check("bnc_ch1_idle", 32'(ch1_any), 32'd0);
        go_quiet("bnc_quiet");

        // ---------------- long press, ch0 repeat on, ch1 off ----------------
        pb_in     = 2'b11;
        repeat_en = 2'b01;
        n = 0;
        while (press_pulse != 2'b11 && n < 20) begin
            tick();
            n++;
        end
        check("lp_press_both", 32'(press_pulse), 32'(2'b11));
        // k = cycles since press (cycle P). Release input drops at P+30,
        // level falls at P+36, release strobe at P+37 beats ch0's repeat.
        for (int k = 0; k <= 45; k++) begin
            e_lvl = (k < 36) ? 2'b11 : 2'b00;
            e_prs = (k == 0) ? 2'b11 : 2'b00;
            e_rel = (k == 37) ? 2'b11 : 2'b00;
            e_rpt[0] = (k >= 10 && k <= 34 && (k - 10) % 3 == 0);
            e_rpt[1] = (k >= 21 && k <= 36 && (k - 21) % 3 == 0);
            e_hld[0] = (k >= 11 && k <= 37);
            e_hld[1] = (k >= 22 && k <= 37);
            check($sformatf("lp_k%0d", k),
                  32'({pb_level, press_pulse, release_pulse, repeat_pulse, held}),
                  32'({e_lvl, e_prs, e_rel, e_rpt, e_hld}));
            if (k == 20) repeat_en = 2'b11;
            if (k == 30) pb_in = 2'b00;
            tick();
        end
        go_quiet("lp_quiet");

        // ---------------- reset in the middle of REPEAT ----------------
        pb_in     = 2'b01;
        repeat_en = 2'b01;
        n = 0;
        while (!held[0] && n < 40) begin
            tick();
            n++;
        end
        check("mr_held_reached", 32'(held[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mr_async_drop");
        for (int k = 0; k < 3; k++) begin
            tick();
            check_zero($sformatf("mr_hold%0d", k));
        end
        #2;
        rst_n = 1'b1;
        clear_counts();
        n = 0;
        while (!pb_level[0] && n < 20) begin
            tick();
            n++;
        end
        check_range("mr_level_edges", n, 6, 7);
        tick();
        check("mr_press", 32'(press_pulse), 32'(2'b01));
        m = 0;
        while (!repeat_pulse[0] && m < 30) begin
            tick();
            m++;
        end
        check("mr_first_repeat", 32'(m), 32'd10);
        for (int k = 0; k < 5; k++) tick();
        check("mr_press_count", 32'(press_cnt0), 32'd1);
        check("mr_no_release", 32'(rel_cnt0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
